alu_result_fifo: RTL and testbench

//   Downstream writeback buffer for the 8-bit combinational ALU. Captures each accepted
//   ALU result with its CF/ZF/SF flags and opcode tag into a DEPTH-entry FIFO. Presents
//   the entries first-word-fall-through on a valid/ready port for the register-file

---
 rtl/alu_result_fifo.sv | 133 +++++++++++++
 tb/tb_alu_result_fifo.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_fifo.sv
// alu_result_fifo: writeback buffer behind the 8-bit ALU.
// Each accepted result is stored with its {SF,ZF,CF} flags and opcode tag in a
// DEPTH-entry circular buffer. Entries are presented first-word-fall-through on
// a valid/ready port. The block also keeps sticky accumulated flags and a sticky
// bit that records a dropped offer.
module alu_result_fifo #(
  parameter int DATA_W = 8,
  parameter int OP_W   = 4,
  parameter int DEPTH  = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [DATA_W-1:0] ALU_OUT,
  input  logic              CF,
  input  logic              ZF,
  input  logic              SF,
  input  logic [OP_W-1:0]   SELC,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [DATA_W-1:0] OUT_DATA,
  output logic [2:0]        OUT_FLAGS,
  output logic [OP_W-1:0]   OUT_OP,
  output logic              OUT_ZERO,
  output logic [CNT_W-1:0]  COUNT,
  output logic [2:0]        STICKY_FLAGS,
  output logic              DROP_ERR,
  input  logic              STICKY_CLR
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_W-1:0] r_mem_data  [DEPTH];
  logic [2:0]        r_mem_flags [DEPTH];
  logic [OP_W-1:0]   r_mem_op    [DEPTH];

  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_rdy;
  logic [2:0]        r_sticky;
  logic              r_drop;

  logic              w_push;
  logic              w_pop;
  logic              w_in_ready;
  logic              w_out_valid;
  logic              w_drop_evt;
  logic [2:0]        w_in_flags;
  logic [DATA_W-1:0] w_head_data;
  logic [2:0]        w_head_flags;
  logic [OP_W-1:0]   w_head_op;

  // Handshake qualification. Input readiness ignores OUT_READY on purpose:
  // a full buffer never accepts, even when the head leaves in the same cycle.
  always_comb begin
    w_in_flags   = {SF, ZF, CF};
    w_in_ready   = r_rdy & (r_count != FULL_CNT);
    w_out_valid  = (r_count != '0);
    w_push       = IN_VALID & w_in_ready;
    w_pop        = w_out_valid & OUT_READY;
    w_drop_evt   = IN_VALID & ~w_in_ready;
    w_head_data  = r_mem_data[r_rd_ptr];
    w_head_flags = r_mem_flags[r_rd_ptr];
    w_head_op    = r_mem_op[r_rd_ptr];
  end

  // Head presentation; all fields read as zero while the buffer is empty.
  // OUT_ZERO is derived from the stored result, not the stored ZF, because
  // the ALU only drives ZF meaningfully for its compare opcode.
  always_comb begin
    IN_READY     = w_in_ready;
    OUT_VALID    = w_out_valid;
    OUT_DATA     = w_out_valid ? w_head_data  : '0;
    OUT_FLAGS    = w_out_valid ? w_head_flags : '0;
    OUT_OP       = w_out_valid ? w_head_op    : '0;
    OUT_ZERO     = w_out_valid & (w_head_data == '0);
    COUNT        = r_count;
    STICKY_FLAGS = r_sticky;
    DROP_ERR     = r_drop;
  end

  // Reset-release flop: input readiness opens on the first edge after RST_N rises.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_rdy <= 1'b0;
    else        r_rdy <= 1'b1;
  end

  // Entry storage, written at the write pointer on every accepted push.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_data[i]  <= '0;
        r_mem_flags[i] <= '0;
        r_mem_op[i]    <= '0;
      end
    end else if (w_push) begin
      r_mem_data[r_wr_ptr]  <= ALU_OUT;
      r_mem_flags[r_wr_ptr] <= w_in_flags;
      r_mem_op[r_wr_ptr]    <= SELC;
    end
  end

  // Pointers wrap naturally at DEPTH (power of two); occupancy is a separate counter.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (w_pop && !w_push) r_count <= r_count - CNT_W'(1);
    end
  end

  // Sticky status: a clear drops the old value first, then this cycle's push
  // flags and drop event are ORed in, so a same-cycle set wins over the clear.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_sticky <= '0;
      r_drop   <= 1'b0;
    end else begin
      r_sticky <= (STICKY_CLR ? 3'b000 : r_sticky) | (w_push ? w_in_flags : 3'b000);
      r_drop   <= (STICKY_CLR ? 1'b0 : r_drop) | w_drop_evt;
    end
  end

endmodule

// File: tb/tb_alu_result_fifo.sv
// Scoreboard bench for alu_result_fifo: the stimulus process queues the
// expected head contents for every push it knows will be accepted, and a
// monitor compares each entry as it leaves the output port.
module tb_alu_result_fifo;

  localparam int DATA_W = 8;
  localparam int OP_W   = 4;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic              CLK = 1'b0;
  logic              RST_N;
  logic              IN_VALID;
  logic              IN_READY;
  logic [DATA_W-1:0] ALU_OUT;
  logic              CF, ZF, SF;
  logic [OP_W-1:0]   SELC;
  logic              OUT_VALID;
  logic              OUT_READY;
  logic [DATA_W-1:0] OUT_DATA;
  logic [2:0]        OUT_FLAGS;
  logic [OP_W-1:0]   OUT_OP;
  logic              OUT_ZERO;
  logic [CNT_W-1:0]  COUNT;
  logic [2:0]        STICKY_FLAGS;
  logic              DROP_ERR;
  logic              STICKY_CLR;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [2:0]        flags;
    logic [OP_W-1:0]   op;
    logic              zero;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  alu_result_fifo #(.DATA_W(DATA_W), .OP_W(OP_W), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .ALU_OUT(ALU_OUT), .CF(CF), .ZF(ZF), .SF(SF), .SELC(SELC),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA),
    .OUT_FLAGS(OUT_FLAGS), .OUT_OP(OUT_OP), .OUT_ZERO(OUT_ZERO), .COUNT(COUNT),
    .STICKY_FLAGS(STICKY_FLAGS), .DROP_ERR(DROP_ERR), .STICKY_CLR(STICKY_CLR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Offer one result; the expected entry is queued only when the caller knows it is accepted.
  task automatic offer(input logic [7:0] d, input logic [2:0] f, input logic [3:0] op,
                       input bit accepted);
    IN_VALID = 1'b1;
    ALU_OUT  = d;
    {SF, ZF, CF} = f;
    SELC     = op;
    if (accepted) exp_q.push_back('{data: d, flags: f, op: op, zero: (d == 8'h00)});
  endtask

  task automatic idle_in();
    IN_VALID = 1'b0;
    ALU_OUT  = '0;
    {SF, ZF, CF} = 3'b000;
    SELC     = '0;
  endtask

  // Monitor: every entry leaving the port must match the oldest expected entry.
  always @(negedge CLK) begin
    if (RST_N && OUT_VALID && OUT_READY) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pop", 32'(OUT_DATA), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("pop_data",  32'(OUT_DATA),  32'(e.data));
        chk("pop_flags", 32'(OUT_FLAGS), 32'(e.flags));
        chk("pop_op",    32'(OUT_OP),    32'(e.op));
        chk("pop_zero",  32'(OUT_ZERO),  32'(e.zero));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RST_N = 1'b0;
    OUT_READY = 1'b0;
    STICKY_CLR = 1'b0;
    idle_in();

    // Reset state and release
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_in_ready",  32'(IN_READY),  32'd0);
    chk("rst_out_valid", 32'(OUT_VALID), 32'd0);
    chk("rst_count",     32'(COUNT),     32'd0);
    chk("rst_out_data",  32'(OUT_DATA),  32'd0);
    chk("rst_drop",      32'(DROP_ERR),  32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    #1;
    chk("rel_in_ready_early", 32'(IN_READY), 32'd0);
    tick();
    chk("rel_in_ready", 32'(IN_READY), 32'd1);

    // Single push, 1-cycle latency
    offer(8'h2A, 3'b001, 4'h0, 1'b1);
    tick();
    idle_in();
    chk("t2_valid", 32'(OUT_VALID), 32'd1);
    chk("t2_data",  32'(OUT_DATA),  32'h2A);
    chk("t2_flags", 32'(OUT_FLAGS), 32'b001);
    chk("t2_op",    32'(OUT_OP),    32'h0);
    chk("t2_zero",  32'(OUT_ZERO),  32'd0);
    chk("t2_count", 32'(COUNT),     32'd1);
    tick();
    chk("t2_hold_data", 32'(OUT_DATA), 32'h2A);
    OUT_READY = 1'b1;
    tick();
    OUT_READY = 1'b0;
    chk("t2_empty_valid", 32'(OUT_VALID), 32'd0);
    chk("t2_empty_data",  32'(OUT_DATA),  32'd0);
    chk("t2_sticky",      32'(STICKY_FLAGS), 32'b001);
    STICKY_CLR = 1'b1;
    tick();
    STICKY_CLR = 1'b0;
    chk("t2_sticky_clr", 32'(STICKY_FLAGS), 32'b000);

    // Fill past full: fifth offer is dropped
    for (int i = 1; i <= 5; i++) begin
      if (i == 5) chk("t3_full_not_ready", 32'(IN_READY), 32'd0);
      offer(8'(i), 3'b000, 4'(i), i <= 4);
      tick();
    end
    idle_in();
    chk("t3_count",    32'(COUNT),    32'd4);
    chk("t3_in_ready", 32'(IN_READY), 32'd0);
    chk("t3_drop",     32'(DROP_ERR), 32'd1);
    OUT_READY = 1'b1;
    repeat (4) tick();
    OUT_READY = 1'b0;
    chk("t3_drained_valid", 32'(OUT_VALID), 32'd0);
    chk("t3_drained_count", 32'(COUNT),     32'd0);
    STICKY_CLR = 1'b1;
    tick();
    STICKY_CLR = 1'b0;
    chk("t3_drop_clr", 32'(DROP_ERR), 32'd0);

    // Simultaneous push/pop at COUNT=2, pointers wrap several times
    offer(8'hA0, 3'b000, 4'h1, 1'b1);
    tick();
    offer(8'hA1, 3'b000, 4'h2, 1'b1);
    tick();
    chk("t4_count_start", 32'(COUNT), 32'd2);
    OUT_READY = 1'b1;
    for (int k = 0; k < 10; k++) begin
      offer(8'hA2 + 8'(k), 3'(k % 8), 4'(k), 1'b1);
      tick();
      chk("t4_count_steady", 32'(COUNT), 32'd2);
    end
    idle_in();
    repeat (2) tick();
    OUT_READY = 1'b0;
    chk("t4_drained", 32'(COUNT), 32'd0);

    // OUT_ZERO from stored data, sticky behaviour
    STICKY_CLR = 1'b1;
    tick();
    STICKY_CLR = 1'b0;
    offer(8'h00, 3'b000, 4'h3, 1'b1);
    tick();
    offer(8'h80, 3'b100, 4'h4, 1'b1);
    tick();
    idle_in();
    chk("t5_zero_head",  32'(OUT_ZERO),     32'd1);
    chk("t5_flags_head", 32'(OUT_FLAGS),    32'b000);
    chk("t5_sticky",     32'(STICKY_FLAGS), 32'b100);
    OUT_READY = 1'b1;
    tick();
    OUT_READY = 1'b0;
    chk("t5_zero_2nd",  32'(OUT_ZERO),  32'd0);
    chk("t5_flags_2nd", 32'(OUT_FLAGS), 32'b100);
    STICKY_CLR = 1'b1;
    offer(8'h07, 3'b001, 4'h5, 1'b1);
    tick();
    STICKY_CLR = 1'b0;
    chk("t5_sticky_clr_set", 32'(STICKY_FLAGS), 32'b001);

    // Fill, drop one, pop one: COUNT=3 with DROP_ERR set, then async reset
    offer(8'h11, 3'b000, 4'h6, 1'b1);
    tick();
    offer(8'h22, 3'b000, 4'h7, 1'b1);
    tick();
    offer(8'h33, 3'b000, 4'h8, 1'b0);
    tick();
    idle_in();
    OUT_READY = 1'b1;
    tick();
    OUT_READY = 1'b0;
    chk("t6_count_pre", 32'(COUNT),     32'd3);
    chk("t6_drop_pre",  32'(DROP_ERR),  32'd1);
    chk("t6_valid_pre", 32'(OUT_VALID), 32'd1);
    #2;
    RST_N = 1'b0;
    exp_q.delete();
    #1;
    chk("t6_async_valid", 32'(OUT_VALID),    32'd0);
    chk("t6_async_count", 32'(COUNT),        32'd0);
    chk("t6_async_drop",  32'(DROP_ERR),     32'd0);
    chk("t6_async_stky",  32'(STICKY_FLAGS), 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    tick();
    chk("t6_ready_again", 32'(IN_READY), 32'd1);
    offer(8'h5A, 3'b010, 4'h9, 1'b1);
    tick();
    offer(8'h5B, 3'b100, 4'hA, 1'b1);
    tick();
    idle_in();
    chk("t6_head_data", 32'(OUT_DATA), 32'h5A);
    OUT_READY = 1'b1;
    repeat (2) tick();
    OUT_READY = 1'b0;
    chk("t6_final_valid", 32'(OUT_VALID), 32'd0);
    chk("t6_scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
